tile_sched_controller: RTL and testbench
========================================

Name: tile_sched_controller

Overview:
- Parametrised successor of the single-tile weight/input-feature controller for the systolic CNN accelerator.
- Sequences a job of NUM_TILES weight tiles. Each tile may be reused for several input-feature passes.
- Prefetches the next weight tile into the shadow buffer while the current tile streams input features.
- Issues a delayed buffer-swap pulse, `switch`, to the array; sits between the top-level command interface and the w/if read engines.

Parameters:
- TILE_W, 8, width of tile count and tile index.
- PASS_W, 8, width of input-feature pass count.
- SWITCH_DLY, 1, cycles from internal swap request to `switch` output (legal range 1..8).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  job request; accepted only when ready=1
- num_tiles  input  TILE_W  tiles in job; latched on start acceptance
- if_passes  input  PASS_W  input-feature passes per tile; latched on start; value 0 treated as 1
- w_done  input  1  weight engine finished current tile load (1-cycle pulse)
- if_done  input  1  if engine finished current pass (1-cycle pulse)
- w_read  output  1  enable weight read engine
- if_read  output  1  enable input-feature read engine
- clr_w  output  1  1-cycle reset of weight engine address state
- clr_if  output  1  1-cycle reset of if engine address state
- switch  output  1  ping-pong weight buffer swap pulse
- ready  output  1  idle, can accept start
- done  output  1  1-cycle job-complete pulse, registered
- tile_idx  output  TILE_W  index of tile currently being streamed

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state IDLE; ready=1; all other outputs 0; tile_idx=0.
  - Pass counter and w_loaded flag cleared.
  - Switch delay pipeline flushed to 0.
- Reset mid-job aborts immediately; no done pulse is issued.
- States: IDLE, PRELOAD, SWAP, STREAM, DRAIN, FINISH.
- IDLE: ready=1.
  - start=1 with num_tiles!=0: latch config, assert clr_w the same cycle (Mealy), next state PRELOAD.
  - start with num_tiles==0: ignored; remain IDLE, no pulses.
- start in any non-IDLE state is ignored.
- PRELOAD: w_read=1 until w_done; on w_done, next state SWAP.
- SWAP (exactly 1 cycle):
  - Internal swap request=1, clr_if=1, pass counter←0, w_loaded←0.
  - clr_w=1 only if tile_idx < num_tiles-1, to start prefetch of the next tile.
  - Next state STREAM.
- STREAM: if_read=1. w_read=1 while tile_idx < num_tiles-1 and w_loaded=0. A w_done pulse sets w_loaded. On if_done:
  - Pass counter < passes-1: counter+1, clr_if=1 that cycle, stay STREAM.
  - Else if last tile: next state FINISH.
  - Else if w_loaded=1, or w_done arrives in the same cycle: tile_idx+1, next state SWAP.
  - Else next state DRAIN.
- DRAIN: if_read=0, w_read=1 until w_done; then tile_idx+1, next state SWAP.
- FINISH: done=1 (registered, visible the cycle after the FINISH entry edge), then IDLE.
- switch = internal swap request delayed by exactly SWITCH_DLY registers.
- Pulses outside an expected state are ignored (w_done in IDLE/FINISH; if_done outside STREAM).
- Pass counter is PASS_W wide and never wraps, since it is compared against passes-1.
- tile_idx is held through FINISH and cleared on the next start acceptance.

Optional Feature:
- Macro: TILE_SCHED_PERF_CNT_EN.
- Defined: adds output stall_cycles [31:0]. Counts cycles spent in DRAIN; cleared on start acceptance; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then num_tiles=1, if_passes=1, start at T0:
  - clr_w at T0; w_read T1..w_done at T3.
  - SWAP at T4, with switch at T5 (SWITCH_DLY=1).
  - if_read from T5; if_done at T9 → done=1 at T11, ready=1 after.
- num_tiles=3, if_passes=2, w_done for the next tile before the second if_done in each tile:
  - Exactly 3 switch pulses, 6 if passes, no DRAIN.
  - tile_idx steps 0→1→2.
- num_tiles=2, w_done for tile 1 arrives 5 cycles after if_done:
  - DRAIN for 5 cycles with if_read=0.
  - stall_cycles=5 with TILE_SCHED_PERF_CNT_EN.
- Same-cycle if_done and w_done in STREAM, num_tiles=2: SWAP on the next cycle, no DRAIN.
- start with num_tiles=0: no output activity, ready stays 1. start asserted during STREAM: ignored.
- rst asserted mid-STREAM with switch pending and SWITCH_DLY=4: all outputs 0, ready=1 the next cycle, no stray switch pulse.

Source files
------------

// File: rtl/tile_sched_controller.sv
// Weight-tile scheduler: preloads tile 0, prefetches tile N+1 into the shadow buffer while tile N streams,
// and emits a SWITCH_DLY-delayed buffer swap pulse. Define TILE_SCHED_PERF_CNT_EN to add the stall_cycles counter.
module tile_sched_controller #(
  parameter int TILE_W     = 8,
  parameter int PASS_W     = 8,
  parameter int SWITCH_DLY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [PASS_W-1:0] if_passes,
  input  logic              w_done,
  input  logic              if_done,
  output logic              w_read,
  output logic              if_read,
  output logic              clr_w,
  output logic              clr_if,
  output logic              switch,
  output logic              ready,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx
`ifdef TILE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    SWAP    = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TILE_W-1:0]   last_tile;
  logic [PASS_W-1:0]   pass_last;
  logic [PASS_W-1:0]   pass_cnt;
  logic                w_loaded;
  logic                has_next;
  logic                accept;
  logic                tile_inc;
  logic                pass_inc;
  logic                swap_req;
  logic [SWITCH_DLY-1:0] swap_req_p;

  // Only meaningful outside IDLE, where last_tile holds the latched job size.
  assign has_next = (tile_idx < last_tile);

  always_comb begin
    state_nxt = state;
    w_read    = 1'b0;
    if_read   = 1'b0;
    clr_w     = 1'b0;
    clr_if    = 1'b0;
    ready     = 1'b0;
    swap_req  = 1'b0;
    accept    = 1'b0;
    tile_inc  = 1'b0;
    pass_inc  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && (num_tiles != '0)) begin
          accept    = 1'b1;
          clr_w     = 1'b1;
          state_nxt = PRELOAD;
        end
      end
      PRELOAD: begin
        w_read = 1'b1;
        if (w_done) state_nxt = SWAP;
      end
      SWAP: begin
        swap_req  = 1'b1;
        clr_if    = 1'b1;
        clr_w     = has_next;
        state_nxt = STREAM;
      end
      STREAM: begin
        if_read = 1'b1;
        w_read  = has_next && !w_loaded;
        if (if_done) begin
          if (pass_cnt < pass_last) begin
            pass_inc = 1'b1;
            clr_if   = 1'b1;
          end else if (!has_next) begin
            state_nxt = FINISH;
          end else if (w_loaded || w_done) begin
            tile_inc  = 1'b1;
            state_nxt = SWAP;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_read = 1'b1;
        if (w_done) begin
          tile_inc  = 1'b1;
          state_nxt = SWAP;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tile_idx <= '0;
      pass_cnt <= '0;
      w_loaded <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINISH);
      if (accept)        tile_idx <= '0;
      else if (tile_inc) tile_idx <= tile_idx + TILE_W'(1);
      if (state == SWAP) pass_cnt <= '0;
      else if (pass_inc) pass_cnt <= pass_cnt + PASS_W'(1);
      if (state == SWAP)                      w_loaded <= 1'b0;
      else if ((state == STREAM) && w_done)   w_loaded <= 1'b1;
    end
  end

  // Job configuration; a pass count of zero behaves as a single pass.
  always_ff @(posedge clk) begin
    if (accept) begin
      last_tile <= num_tiles - TILE_W'(1);
      pass_last <= (if_passes == '0) ? '0 : (if_passes - PASS_W'(1));
    end
  end

  // ---- swap delay line: stage 0 .. SWITCH_DLY-1 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_req_p <= '0;
    end else begin
      swap_req_p[0] <= swap_req;
      for (int i = 1; i < SWITCH_DLY; i++) swap_req_p[i] <= swap_req_p[i-1];
    end
  end

  assign switch = swap_req_p[SWITCH_DLY-1];

`ifdef TILE_SCHED_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                  stall_cycles <= '0;
    else if (accept)          stall_cycles <= '0;
    else if (state == DRAIN)  stall_cycles <= sat_inc32(stall_cycles);
  end
`endif

endmodule

// File: tb/tb_tile_sched_controller.sv
// Bench for tile_sched_controller: two instances (SWITCH_DLY 1 and 4) checked every cycle against a
// job-level reference model, plus directed scenarios with hand-computed expectations.
module tb_tile_sched_controller;
  localparam int TW = 8;
  localparam int PW = 8;
  localparam int DLY0 = 1;
  localparam int DLY1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic w_done = 1'b0;
  logic if_done = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [PW-1:0] if_passes = '0;

  logic w_read_o [2];
  logic if_read_o[2];
  logic clr_w_o  [2];
  logic clr_if_o [2];
  logic switch_o [2];
  logic ready_o  [2];
  logic done_o   [2];
  logic [TW-1:0] tile_o[2];
`ifdef TILE_SCHED_PERF_CNT_EN
  logic [31:0] stall_o[2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  tile_sched_controller #(.TILE_W(TW), .PASS_W(PW), .SWITCH_DLY(DLY0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .if_passes(if_passes),
    .w_done(w_done), .if_done(if_done), .w_read(w_read_o[0]), .if_read(if_read_o[0]),
    .clr_w(clr_w_o[0]), .clr_if(clr_if_o[0]), .switch(switch_o[0]), .ready(ready_o[0]),
    .done(done_o[0]), .tile_idx(tile_o[0])
`ifdef TILE_SCHED_PERF_CNT_EN
    , .stall_cycles(stall_o[0])
`endif
  );

  tile_sched_controller #(.TILE_W(TW), .PASS_W(PW), .SWITCH_DLY(DLY1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .if_passes(if_passes),
    .w_done(w_done), .if_done(if_done), .w_read(w_read_o[1]), .if_read(if_read_o[1]),
    .clr_w(clr_w_o[1]), .clr_if(clr_if_o[1]), .switch(switch_o[1]), .ready(ready_o[1]),
    .done(done_o[1]), .tile_idx(tile_o[1])
`ifdef TILE_SCHED_PERF_CNT_EN
    , .stall_cycles(stall_o[1])
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job-level view) ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_SWAP = 2, M_STREAM = 3, M_DRAIN = 4, M_FIN = 5;
  int  cyc      = 0;
  int  m_ph     = M_IDLE;
  int  m_tiles  = 1;
  int  m_passes = 1;
  int  m_tile   = 0;
  int  m_pass   = 0;
  bit  m_next   = 1'b0;
  longint m_stall = 0;
  int  last_rst = -100;
  int  fin_at   = -100;
  bit  swap_at[int];

  always @(posedge clk) begin
    int c;
    bit had_next;
    c = cyc;
    if (m_ph == M_SWAP) swap_at[c] = 1'b1;
    if (m_ph == M_FIN)  fin_at = c;
    if (rst) begin
      last_rst = c;
      m_ph = M_IDLE; m_tile = 0; m_pass = 0; m_next = 1'b0; m_stall = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (start && num_tiles != 0) begin
          m_tiles  = int'(num_tiles);
          m_passes = (if_passes == 0) ? 1 : int'(if_passes);
          m_tile = 0; m_stall = 0; m_ph = M_LOAD;
        end
        M_LOAD: if (w_done) m_ph = M_SWAP;
        M_SWAP: begin m_pass = 0; m_next = 1'b0; m_ph = M_STREAM; end
        M_STREAM: begin
          had_next = m_next;
          if (w_done) m_next = 1'b1;
          if (if_done) begin
            if (m_pass < m_passes - 1)          m_pass++;
            else if (m_tile == m_tiles - 1)     m_ph = M_FIN;
            else if (had_next || w_done) begin  m_tile++; m_ph = M_SWAP; end
            else                                m_ph = M_DRAIN;
          end
        end
        M_DRAIN: begin
          m_stall++;
          if (w_done) begin m_tile++; m_ph = M_SWAP; end
        end
        default: m_ph = M_IDLE;
      endcase
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin
    bit e_ready, e_clr_w, e_w_read, e_if_read, e_clr_if, e_done, e_sw;
    int d;
    if (chk_en) begin
      e_ready   = (m_ph == M_IDLE);
      e_clr_w   = (m_ph == M_IDLE && start && num_tiles != 0) ||
                  (m_ph == M_SWAP && m_tile < m_tiles - 1);
      e_w_read  = (m_ph == M_LOAD) || (m_ph == M_DRAIN) ||
                  (m_ph == M_STREAM && m_tile < m_tiles - 1 && !m_next);
      e_if_read = (m_ph == M_STREAM);
      e_clr_if  = (m_ph == M_SWAP) || (m_ph == M_STREAM && if_done && m_pass < m_passes - 1);
      e_done    = (fin_at == cyc - 1) && (last_rst != cyc - 1);
      for (int k = 0; k < 2; k++) begin
        d    = (k == 0) ? DLY0 : DLY1;
        e_sw = swap_at.exists(cyc - d) && (last_rst < cyc - d);
        chk($sformatf("model c%0d u%0d ready",   cyc, k), ready_o[k],   e_ready);
        chk($sformatf("model c%0d u%0d clr_w",   cyc, k), clr_w_o[k],   e_clr_w);
        chk($sformatf("model c%0d u%0d w_read",  cyc, k), w_read_o[k],  e_w_read);
        chk($sformatf("model c%0d u%0d if_read", cyc, k), if_read_o[k], e_if_read);
        chk($sformatf("model c%0d u%0d clr_if",  cyc, k), clr_if_o[k],  e_clr_if);
        chk($sformatf("model c%0d u%0d done",    cyc, k), done_o[k],    e_done);
        chk($sformatf("model c%0d u%0d switch",  cyc, k), switch_o[k],  e_sw);
        chk($sformatf("model c%0d u%0d tile",    cyc, k), tile_o[k],    m_tile);
`ifdef TILE_SCHED_PERF_CNT_EN
        chk($sformatf("model c%0d u%0d stall",   cyc, k), stall_o[k],   m_stall);
`endif
      end
    end
  end

  // Pulse counters for whole-job checks.
  int sw_cnt = 0;
  int ci_cnt = 0;
  always @(negedge clk) begin
    if (switch_o[0]) sw_cnt++;
    if (clr_if_o[0]) ci_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; start = 1'b0; w_done = 1'b0; if_done = 1'b0;
    tick(); rst = 1'b0;
  endtask

  initial begin
    int sw0, ci0, dcnt;
    tick(); rst = 1'b1;
    tick(); chk_en = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("reset ready", ready_o[0], 1);
    chk("reset w_read", w_read_o[0], 0);
    chk("reset if_read", if_read_o[0], 0);
    chk("reset switch", switch_o[0], 0);
    chk("reset done", done_o[0], 0);
    chk("reset tile", tile_o[0], 0);

    // One tile, one pass.
    for (int t = 0; t <= 13; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd1; if_passes = 8'd1;
      w_done = (t == 3); if_done = (t == 9);
      @(negedge clk);
      if (t == 0)  chk("j1 clr_w T0", clr_w_o[0], 1);
      if (t == 1)  begin chk("j1 w_read T1", w_read_o[0], 1); chk("j1 ready T1", ready_o[0], 0); end
      if (t == 4)  begin chk("j1 clr_if T4", clr_if_o[0], 1); chk("j1 switch T4", switch_o[0], 0); end
      if (t == 5)  begin chk("j1 switch T5", switch_o[0], 1); chk("j1 if_read T5", if_read_o[0], 1); end
      if (t == 10) chk("j1 done T10", done_o[0], 0);
      if (t == 11) begin chk("j1 done T11", done_o[0], 1); chk("j1 ready T11", ready_o[0], 1); end
      if (t == 12) chk("j1 done T12", done_o[0], 0);
    end

    // Three tiles, two passes, prefetch always completes in time.
    do_reset();
    sw0 = sw_cnt; ci0 = ci_cnt;
    for (int t = 0; t <= 23; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd3; if_passes = 8'd2;
      w_done  = (t == 3) || (t == 6) || (t == 12);
      if_done = (t == 7) || (t == 9) || (t == 13) || (t == 15) || (t == 18) || (t == 20);
      @(negedge clk);
      if (t == 5)  chk("j2 tile T5", tile_o[0], 0);
      if (t == 11) chk("j2 tile T11", tile_o[0], 1);
      if (t == 17) chk("j2 tile T17", tile_o[0], 2);
      if (t == 22) chk("j2 done T22", done_o[0], 1);
    end
    tick();
    chk("j2 switch pulses", sw_cnt - sw0, 3);
    chk("j2 clr_if pulses", ci_cnt - ci0, 6);

    // Two tiles, late prefetch: five DRAIN cycles.
    do_reset();
    dcnt = 0;
    for (int t = 0; t <= 17; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd2; if_passes = 8'd1;
      w_done = (t == 3) || (t == 11); if_done = (t == 6) || (t == 14);
      @(negedge clk);
      if (t >= 7 && t <= 11 && !if_read_o[0] && w_read_o[0]) dcnt++;
      if (t == 12) begin chk("j3 clr_if T12", clr_if_o[0], 1); chk("j3 tile T12", tile_o[0], 1); end
      if (t == 16) chk("j3 done T16", done_o[0], 1);
`ifdef TILE_SCHED_PERF_CNT_EN
      if (t == 16) chk("j3 stall_cycles", stall_o[0], 5);
`endif
    end
    chk("j3 drain cycles", dcnt, 5);

    // Same-cycle if_done and w_done: straight to SWAP.
    do_reset();
    for (int t = 0; t <= 13; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd2; if_passes = 8'd1;
      w_done = (t == 3) || (t == 7); if_done = (t == 7) || (t == 10);
      @(negedge clk);
      if (t == 8)  begin chk("j4 clr_if T8", clr_if_o[0], 1); chk("j4 tile T8", tile_o[0], 1); end
      if (t == 9)  begin chk("j4 switch T9", switch_o[0], 1); chk("j4 if_read T9", if_read_o[0], 1); end
      if (t == 12) chk("j4 done T12", done_o[0], 1);
    end

    // Zero-tile start is ignored.
    do_reset();
    for (int t = 0; t <= 3; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd0; if_passes = 8'd1; w_done = 1'b0; if_done = 1'b0;
      @(negedge clk);
      if (t == 0) chk("j5 clr_w zero", clr_w_o[0], 0);
      if (t == 2) begin chk("j5 ready", ready_o[0], 1); chk("j5 w_read", w_read_o[0], 0); end
    end

    // start during STREAM is ignored.
    for (int t = 0; t <= 11; t++) begin
      tick();
      start = (t == 0) || (t == 6); num_tiles = (t == 6) ? 8'd5 : 8'd1; if_passes = 8'd1;
      w_done = (t == 3); if_done = (t == 8);
      @(negedge clk);
      if (t == 6)  begin chk("j6 clr_w busy", clr_w_o[0], 0); chk("j6 if_read T6", if_read_o[0], 1); end
      if (t == 7)  begin chk("j6 if_read T7", if_read_o[0], 1); chk("j6 tile T7", tile_o[0], 0); end
      if (t == 10) chk("j6 done T10", done_o[0], 1);
    end

    // Reset mid-STREAM with a swap still in flight in the 4-deep delay line.
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      tick();
      start = (t == 0); num_tiles = 8'd2; if_passes = 8'd2;
      w_done = (t == 3); if_done = 1'b0; rst = (t == 5);
      @(negedge clk);
      if (t == 4) chk("j7 clr_if T4", clr_if_o[1], 1);
      if (t == 6) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("j7 u%0d ready", k), ready_o[k], 1);
          chk($sformatf("j7 u%0d w_read", k), w_read_o[k], 0);
          chk($sformatf("j7 u%0d if_read", k), if_read_o[k], 0);
          chk($sformatf("j7 u%0d clr_w", k), clr_w_o[k], 0);
          chk($sformatf("j7 u%0d done", k), done_o[k], 0);
          chk($sformatf("j7 u%0d tile", k), tile_o[k], 0);
        end
      end
      if (t >= 6) chk($sformatf("j7 stray switch T%0d", t), switch_o[1], 0);
    end

    // Randomised traffic, including stray pulses and occasional resets.
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      tick();
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      num_tiles = 8'($urandom_range(0, 4));
      if_passes = 8'($urandom_range(0, 3));
      w_done    = ($urandom_range(0, 3) == 0);
      if_done   = ($urandom_range(0, 2) == 0);
    end
    tick();
    rst = 1'b0; start = 1'b0; w_done = 1'b0; if_done = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
